// File: rtl/seg_scan_mux.sv
// Purpose : time-multiplexed common-anode seven-segment scanner with per-digit enable,
//           leading-zero suppression, anti-ghost blanking, 16-level PWM and frame snapshot.
// Latency : all outputs registered; outputs at cycle t+1 reflect counter/snapshot state at t.
// Backpressure: none; free-running scan, inputs sampled only at the frame boundary.
//
// Ports:
//   clk, reset_n      - clock, asynchronous active-low reset
//   digits_in         - NUM_DIGITS packed codes, digit 0 at the LSBs (rightmost)
//   dp_in, digit_en   - per-digit decimal point request / enable
//   lzs_en            - leading-zero suppression enable
//   bright            - PWM level, duty in the active window = (bright+1)/16
//   hold              - freeze the current snapshot
//   an                - active-low anodes; digit/dp/sel - selected code, point, index
//   frame_start       - one-cycle pulse in the output cycle of slot 0, count 0
module seg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_W      = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int SEL_W        = $clog2(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic                          lzs_en,
    input  logic [3:0]                    bright,
    input  logic                          hold,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [DIGIT_W-1:0]            digit,
    output logic                          dp,
    output logic [SEL_W-1:0]              sel,
    output logic                          frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    // scan position
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] slot;

    // frame snapshot
    logic [NUM_DIGITS*DIGIT_W-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]         sh_dp;
    logic [NUM_DIGITS-1:0]         sh_en;

    // combinational next-output terms
    logic                          frame_edge;
    logic                          snap;
    logic [NUM_DIGITS*DIGIT_W-1:0] eff_digits;
    logic [NUM_DIGITS-1:0]         eff_dp;
    logic [NUM_DIGITS-1:0]         eff_en;
    logic [DIGIT_W-1:0]            code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]         supp;
    logic                          all_zero;
    logic                          active;
    logic [3:0]                    pwm_ph;
    logic                          lit;
    logic [NUM_DIGITS-1:0]         an_nxt;

    always_comb begin
        frame_edge = (cnt == '0) && (slot == '0);
        snap       = frame_edge && !hold;

        // The output cycle computed on the snapshot edge already uses the freshly
        // captured values, so a frame is never shown with a mix of old and new data.
        eff_digits = snap ? digits_in : sh_digits;
        eff_dp     = snap ? dp_in     : sh_dp;
        eff_en     = snap ? digit_en  : sh_en;

        for (int i = 0; i < NUM_DIGITS; i++) begin
            code[i] = eff_digits[i*DIGIT_W +: DIGIT_W];
        end

        // Walk from the most significant digit down; a digit is a leading zero
        // while every digit from it upward is zero. Digit 0 always shows.
        supp     = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (code[i] == '0);
            supp[i]  = lzs_en & all_zero & (i != 0);
        end

        // Subtraction only matters in the active phase; the truncation to 4 bits
        // gives the position within the 16-cycle PWM period.
        active = (cnt >= CNT_W'(BLANK_CYCLES));
        pwm_ph = 4'(cnt - CNT_W'(BLANK_CYCLES));
        lit    = active && (pwm_ph <= bright) && eff_en[slot] && !supp[slot];

        an_nxt = '1;
        if (lit) begin
            an_nxt[slot] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            slot <= '0;
        end else if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
            cnt  <= '0;
            slot <= (slot == SEL_W'(NUM_DIGITS - 1)) ? '0 : slot + SEL_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_en     <= '0;
        end else if (snap) begin
            sh_digits <= digits_in;
            sh_dp     <= dp_in;
            sh_en     <= digit_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an          <= '1;
            digit       <= '0;
            dp          <= 1'b0;
            sel         <= '0;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            digit       <= code[slot];
            dp          <= eff_dp[slot] && lit;
            sel         <= slot;
            frame_start <= frame_edge;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

    localparam int ND = 4;
    localparam int DW = 4;
    localparam int RD = 32;
    localparam int BC = 4;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [ND*DW-1:0] digits_in;
    logic [ND-1:0]  dp_in;
    logic [ND-1:0]  digit_en;
    logic           lzs_en;
    logic [3:0]     bright;
    logic           hold;
    logic [ND-1:0]  an;
    logic [DW-1:0]  digit;
    logic           dp;
    logic [SW-1:0]  sel;
    logic           frame_start;

    seg_scan_mux #(
        .NUM_DIGITS  (ND),
        .DIGIT_W     (DW),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC),
        .SEL_W       (SW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lzs_en     (lzs_en),
        .bright     (bright),
        .hold       (hold),
        .an         (an),
        .digit      (digit),
        .dp         (dp),
        .sel        (sel),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0]     digits;
        logic [3:0]      dpv;
        logic [3:0]      en;
        logic            lzs;
        logic [3:0]      br;
        logic [3:0][7:0] lit;   // expected lit cycles per slot
        logic [3:0][3:0] dig;   // expected digit code per slot
        logic [3:0][7:0] dpn;   // expected dp-high cycles per slot
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int pos      = 0;   // output-cycle index within the current frame

    function automatic vec_t mk(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e,
                                input logic z, input logic [3:0] b,
                                input int l0, input int l1, input int l2, input int l3,
                                input int g0, input int g1, input int g2, input int g3,
                                input int p0, input int p1, input int p2, input int p3);
        vec_t v;
        v.digits = d; v.dpv = p; v.en = e; v.lzs = z; v.br = b;
        v.lit[0] = 8'(l0); v.lit[1] = 8'(l1); v.lit[2] = 8'(l2); v.lit[3] = 8'(l3);
        v.dig[0] = 4'(g0); v.dig[1] = 4'(g1); v.dig[2] = 4'(g2); v.dig[3] = 4'(g3);
        v.dpn[0] = 8'(p0); v.dpn[1] = 8'(p1); v.dpn[2] = 8'(p2); v.dpn[3] = 8'(p3);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic step_to(input int p);
        while (pos < p) step();
    endtask

    // Advance until a sampled frame_start; leaves pos=0 on that sample.
    task automatic sync_frame();
        int n;
        for (n = 0; n < 300; n++) begin
            step();
            if (frame_start) break;
        end
        chk("frame_start_seen", int'(frame_start), 1);
        pos = 0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int sel_err, an_err, fs_err, dp_err;
        int s, c;
        int lit_c [4];
        int dp_c  [4];
        int dg    [4];
        logic [3:0] ea;
        sel_err = 0; an_err = 0; fs_err = 0; dp_err = 0;
        for (int j = 0; j < 4; j++) begin
            lit_c[j] = 0; dp_c[j] = 0; dg[j] = -1;
        end
        digits_in = v.digits; dp_in = v.dpv; digit_en = v.en; lzs_en = v.lzs; bright = v.br;
        hold = 1'b0;
        sync_frame();
        for (int i = 0; i < 128; i++) begin
            s = i / 32;
            c = i % 32;
            ea = 4'hF;
            if (v.lit[s] != 0 && c >= BC && (((c - BC) % 16) <= int'(v.br))) ea[s] = 1'b0;
            if (int'(sel) != s) sel_err++;
            if (frame_start != (i == 0)) fs_err++;
            if (an != ea) an_err++;
            if (!an[s]) lit_c[s]++;
            if (dp) dp_c[s]++;
            if (dp && an[s]) dp_err++;
            if (c == 31) dg[s] = int'(digit);
            step();
        end
        chk($sformatf("v%0d_frame_start_period", k), int'(frame_start), 1);
        chk($sformatf("v%0d_sel_errs", k), sel_err, 0);
        chk($sformatf("v%0d_fs_errs", k), fs_err, 0);
        chk($sformatf("v%0d_an_errs", k), an_err, 0);
        chk($sformatf("v%0d_dp_unlit_errs", k), dp_err, 0);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("v%0d_lit_s%0d", k, j), lit_c[j], int'(v.lit[j]));
            chk($sformatf("v%0d_digit_s%0d", k, j), dg[j], int'(v.dig[j]));
            chk($sformatf("v%0d_dp_s%0d", k, j), dp_c[j], int'(v.dpn[j]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        vecs[0] = mk(16'h1234, 4'b0000, 4'hF, 1'b0, 4'd15, 28, 28, 28, 28, 4, 3, 2, 1, 0, 0, 0, 0);
        vecs[1] = mk(16'h0050, 4'b0000, 4'hF, 1'b1, 4'd15, 28, 28, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        vecs[2] = mk(16'h0000, 4'b0000, 4'hF, 1'b1, 4'd15, 28, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3] = mk(16'h1234, 4'b0000, 4'hF, 1'b0, 4'd3, 8, 8, 8, 8, 4, 3, 2, 1, 0, 0, 0, 0);
        vecs[4] = mk(16'h1234, 4'b0000, 4'hF, 1'b0, 4'd0, 2, 2, 2, 2, 4, 3, 2, 1, 0, 0, 0, 0);
        vecs[5] = mk(16'h1234, 4'b0100, 4'b1011, 1'b0, 4'd15, 28, 28, 0, 28, 4, 3, 2, 1, 0, 0, 0, 0);
        vecs[6] = mk(16'h1234, 4'b0100, 4'hF, 1'b0, 4'd15, 28, 28, 28, 28, 4, 3, 2, 1, 0, 0, 28, 0);
        vecs[7] = mk(16'h0005, 4'b1000, 4'hF, 1'b1, 4'd15, 28, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        vecs[8] = mk(16'h1234, 4'b0000, 4'b0111, 1'b0, 4'd7, 16, 16, 16, 0, 4, 3, 2, 1, 0, 0, 0, 0);

        reset_n = 1'b0;
        digits_in = 16'h1234; dp_in = 4'hF; digit_en = 4'hF;
        lzs_en = 1'b0; bright = 4'd15; hold = 1'b0;
        #12;
        chk("rst_an", int'(an), 15);
        chk("rst_sel", int'(sel), 0);
        chk("rst_digit", int'(digit), 0);
        chk("rst_dp", int'(dp), 0);
        chk("rst_fs", int'(frame_start), 0);

        @(negedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("first_fs_after_release", int'(frame_start), 1);
        pos = 0;

        for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

        // mid-frame input change must not tear the displayed frame
        digits_in = 16'h1234; dp_in = 4'h0; digit_en = 4'hF; lzs_en = 1'b0; bright = 4'd15;
        hold = 1'b0;
        sync_frame();
        step_to(40);
        digits_in = 16'h5678;
        step_to(95);
        chk("tear_slot2_old", int'(digit), 2);
        step_to(127);
        chk("tear_slot3_old", int'(digit), 1);
        sync_frame();
        step_to(31);
        chk("tear_slot0_new", int'(digit), 8);
        step_to(63);
        chk("tear_slot1_new", int'(digit), 7);

        // hold across a boundary keeps the old snapshot; release updates next frame
        hold = 1'b1;
        digits_in = 16'h4321;
        sync_frame();
        step_to(31);
        chk("hold_slot0_old", int'(digit), 8);
        step_to(40);
        hold = 1'b0;
        step_to(127);
        chk("hold_slot3_old", int'(digit), 5);
        sync_frame();
        step_to(31);
        chk("hold_release_slot0", int'(digit), 1);

        // asynchronous reset in the middle of slot 2
        step_to(81);
        chk("pre_reset_an", int'(an), 4'b1011);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_an", int'(an), 15);
        chk("async_rst_sel", int'(sel), 0);
        chk("async_rst_digit", int'(digit), 0);
        chk("async_rst_dp", int'(dp), 0);
        digits_in = 16'h0907;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_held_an", int'(an), 15);
        @(negedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        pos = 0;
        chk("rel_fs", int'(frame_start), 1);
        chk("rel_an_blank0", int'(an), 15);
        step();
        chk("rel_fs_single", int'(frame_start), 0);
        step_to(3);
        chk("rel_an_blank3", int'(an), 15);
        step();
        chk("rel_an_slot0_lit", int'(an), 4'b1110);
        chk("rel_digit_snapshot", int'(digit), 7);
        chk("rel_sel", int'(sel), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
